// File: rtl/rv32i_types.sv
// Shared rename/retire types for the rv32i out-of-order core.
package rv32i_types;

  localparam int PROCESSOR_WIDTH = 1;
  localparam int PHYS_REGS       = 64;
  localparam int ARCH_REGS       = 32;
  localparam int PHYS_WIDTH      = $clog2(PHYS_REGS);
  localparam int FREE_DEPTH      = PHYS_REGS - ARCH_REGS;
  localparam int FREE_PTR_W      = $clog2(FREE_DEPTH) + 1;

  typedef logic [PHYS_WIDTH-1:0] phys_tag_t;

endpackage

// File: rtl/fl_lane_select.sv
// Prefix popcount over lane enables: rank[i] is the number of enabled lanes
// below lane i, total is the number of enabled lanes.
module fl_lane_select #(
  parameter int W     = 1,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]            en,
  output logic [W-1:0][CNT_W-1:0] rank,
  output logic [CNT_W-1:0]        total
);

  logic [CNT_W-1:0] acc;

  // Running sum in lane order; each lane sees the sum before its own bit.
  always_comb begin
    acc  = '0;
    rank = '0;
    for (int i = 0; i < W; i++) begin
      rank[i] = acc;
      acc     = acc + CNT_W'(en[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/free_list_ctrl.sv
// Physical-register free list: circular tag buffer with head (rename side),
// tail (release side) and retire_head (commit side) pointers. A flush
// snaps head back to the commit-side pointer so the speculative allocations
// are returned in a single cycle.
//
// Handshake: alloc_valid[i] is an offer that does not depend on alloc_req[i];
// a grant (fire) happens only in a cycle where alloc_valid[i] && alloc_req[i],
// and the offered alloc_preg[i] is consumed at the following clock edge.
// Release and commit are unconditional pulses with no back-pressure.
//
// Pointer arithmetic relies on DEPTH being a power of two so that the
// PTR_W-bit pointers wrap naturally with the MSB acting as the wrap bit.
module free_list_ctrl #(
  parameter int PROCESSOR_WIDTH = rv32i_types::PROCESSOR_WIDTH,
  parameter int PHYS_REGS       = rv32i_types::PHYS_REGS,
  parameter int ARCH_REGS       = rv32i_types::ARCH_REGS,
  parameter int PHYS_WIDTH      = $clog2(PHYS_REGS),
  parameter int DEPTH           = PHYS_REGS - ARCH_REGS,
  parameter int PTR_W           = $clog2(DEPTH) + 1,
  parameter bit CHECK_OVERFLOW  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PROCESSOR_WIDTH-1:0] alloc_req,
  output logic [PROCESSOR_WIDTH-1:0] alloc_valid,
  output logic [PHYS_WIDTH-1:0]      alloc_preg [PROCESSOR_WIDTH],
  input  logic [PROCESSOR_WIDTH-1:0] commit_alloc,
  input  logic [PROCESSOR_WIDTH-1:0] release_en,
  input  logic [PHYS_WIDTH-1:0]      release_preg [PROCESSOR_WIDTH],
  input  logic                       flush,
  output logic [PTR_W-1:0]           free_count,
  output logic                       empty,
  output logic                       overflow_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(PROCESSOR_WIDTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PHYS_WIDTH-1:0] tag_t;

  tag_t entries_q [DEPTH];
  tag_t entries_d [DEPTH];
  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  ptr_t retire_head_q, retire_head_d;
  logic overflow_q, overflow_d;

  logic [PROCESSOR_WIDTH-1:0] fire;
  logic [PROCESSOR_WIDTH-1:0] rel_ok;
  logic [PROCESSOR_WIDTH-1:0] rel_accept;
  logic                       drop_any;
  logic                       prev_fire;
  ptr_t                       offer_ptr;
  ptr_t                       write_ptr;
  ptr_t                       room;
  ptr_t                       rel_cnt;

  logic [PROCESSOR_WIDTH-1:0][CNT_W-1:0] alloc_rank;
  logic [PROCESSOR_WIDTH-1:0][CNT_W-1:0] commit_rank;
  logic [PROCESSOR_WIDTH-1:0][CNT_W-1:0] rel_rank;
  logic [CNT_W-1:0]                      alloc_total;
  logic [CNT_W-1:0]                      commit_total;
  logic [CNT_W-1:0]                      rel_total;

  // Per-lane ranks only matter on the release side; alloc and commit use the totals.
  logic unused_ranks;
  assign unused_ranks = ^{alloc_rank, commit_rank, rel_total};

  fl_lane_select #(.W(PROCESSOR_WIDTH), .CNT_W(CNT_W)) u_alloc_sel (
    .en    (fire),
    .rank  (alloc_rank),
    .total (alloc_total)
  );

  fl_lane_select #(.W(PROCESSOR_WIDTH), .CNT_W(CNT_W)) u_commit_sel (
    .en    (commit_alloc),
    .rank  (commit_rank),
    .total (commit_total)
  );

  fl_lane_select #(.W(PROCESSOR_WIDTH), .CNT_W(CNT_W)) u_release_sel (
    .en    (rel_ok),
    .rank  (rel_rank),
    .total (rel_total)
  );

  assign free_count   = tail_q - head_q;
  assign empty        = (free_count == '0);
  assign overflow_err = overflow_q;

  // Offer consecutive entries from head; a lane is only offered a tag when
  // every lower lane fires, keeping grants strictly in order.
  always_comb begin
    prev_fire   = 1'b1;
    offer_ptr   = '0;
    alloc_valid = '0;
    fire        = '0;
    for (int i = 0; i < PROCESSOR_WIDTH; i++) begin
      offer_ptr      = head_q + PTR_W'(i);
      alloc_preg[i]  = entries_q[offer_ptr[IDX_W-1:0]];
      alloc_valid[i] = !flush && (free_count > PTR_W'(i)) && prev_fire;
      fire[i]        = alloc_req[i] && alloc_valid[i];
      prev_fire      = fire[i];
    end
  end

  // Release acceptance: preg 0 is never freed, and lanes beyond the free
  // room are dropped (and latched as an overflow error).
  always_comb begin
    room       = PTR_W'(DEPTH) - free_count;
    rel_cnt    = '0;
    rel_ok     = '0;
    rel_accept = '0;
    for (int i = 0; i < PROCESSOR_WIDTH; i++) begin
      rel_ok[i]     = release_en[i] && (release_preg[i] != '0);
      rel_accept[i] = rel_ok[i] && (PTR_W'(rel_rank[i]) < room);
      rel_cnt       = rel_cnt + PTR_W'(rel_accept[i]);
    end
    drop_any   = |(rel_ok & ~rel_accept);
    overflow_d = overflow_q | drop_any;
  end

  // Accepted releases fill the slots starting at tail, in lane order.
  always_comb begin
    entries_d = entries_q;
    write_ptr = '0;
    for (int i = 0; i < PROCESSOR_WIDTH; i++) begin
      if (rel_accept[i]) begin
        write_ptr                        = tail_q + PTR_W'(rel_rank[i]);
        entries_d[write_ptr[IDX_W-1:0]]  = release_preg[i];
      end
    end
    tail_d = tail_q + rel_cnt;
  end

  // Commit advances retire_head; flush restores head to it, same-cycle commits included.
  always_comb begin
    retire_head_d = retire_head_q + PTR_W'(commit_total);
    if (flush) begin
      head_d = retire_head_d;
    end else begin
      head_d = head_q + PTR_W'(alloc_total);
    end
  end

  // State registers; reset refills the list with tags ARCH_REGS..PHYS_REGS-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      retire_head_q <= '0;
      tail_q        <= PTR_W'(DEPTH);
      overflow_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= PHYS_WIDTH'(ARCH_REGS + i);
      end
    end else begin
      head_q        <= head_d;
      retire_head_q <= retire_head_d;
      tail_q        <= tail_d;
      overflow_q    <= overflow_d;
      entries_q     <= entries_d;
    end
  end

  a_free_bound: assert property (@(posedge clk) disable iff (rst)
    free_count <= PTR_W'(DEPTH));

  a_retire_window: assert property (@(posedge clk) disable iff (rst)
    (tail_q - retire_head_q) <= PTR_W'(DEPTH));

  generate
    if (CHECK_OVERFLOW) begin : g_overflow_chk
      a_no_overflow: assert property (@(posedge clk) disable iff (rst) !drop_any);
    end
  endgenerate

endmodule

// File: tb/tb_free_list_ctrl.sv
// Directed bench for free_list_ctrl: grants are checked by a scoreboard
// monitor, status outputs by direct checks from the stimulus thread.
module tb_free_list_ctrl;

  logic       clk;
  logic       rst;
  logic [0:0] alloc_req;
  logic [0:0] alloc_valid;
  logic [5:0] alloc_preg [1];
  logic [0:0] commit_alloc;
  logic [0:0] release_en;
  logic [5:0] release_preg [1];
  logic       flush;
  logic [5:0] free_count;
  logic       empty;
  logic       overflow_err;

  int checks   = 0;
  int failures = 0;
  logic [5:0] exp_q [$];

  free_list_ctrl #(.CHECK_OVERFLOW(1'b0)) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req    (alloc_req),
    .alloc_valid  (alloc_valid),
    .alloc_preg   (alloc_preg),
    .commit_alloc (commit_alloc),
    .release_en   (release_en),
    .release_preg (release_preg),
    .flush        (flush),
    .free_count   (free_count),
    .empty        (empty),
    .overflow_err (overflow_err)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every grant must match the next expected tag.
  always @(negedge clk) begin
    if (!rst && alloc_req[0] && alloc_valid[0]) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL grant: unexpected grant of preg %0d, none expected", alloc_preg[0]);
      end else begin
        logic [5:0] exp_tag;
        exp_tag = exp_q.pop_front();
        if (alloc_preg[0] !== exp_tag) begin
          failures++;
          $display("FAIL grant: got preg %0d, expected %0d", alloc_preg[0], exp_tag);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    alloc_req       = '0;
    commit_alloc    = '0;
    release_en      = '0;
    release_preg[0] = '0;
    flush           = 1'b0;
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    rst = 1'b0;
  endtask

  // Driver: issue n back-to-back allocations expecting tags start..start+n-1.
  task automatic alloc_run(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      alloc_req = 1'b1;
      exp_q.push_back(6'(start + i));
      next_cycle();
    end
    alloc_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset_valid", 32'(alloc_valid[0]), 1);
    chk("reset_preg", 32'(alloc_preg[0]), 32);
    chk("reset_count", 32'(free_count), 32);
    chk("reset_empty", 32'(empty), 0);
    chk("reset_ovf", 32'(overflow_err), 0);
    next_cycle();

    // Drain: 32 allocs return 32..63 in order, count decrements each cycle
    for (int i = 0; i < 32; i++) begin
      alloc_req = 1'b1;
      exp_q.push_back(6'(32 + i));
      @(negedge clk);
      chk("drain_count", 32'(free_count), 32'(32 - i));
      next_cycle();
    end
    alloc_req = 1'b0;
    @(negedge clk);
    chk("drained_empty", 32'(empty), 1);
    chk("drained_valid", 32'(alloc_valid[0]), 0);
    chk("drained_count", 32'(free_count), 0);
    next_cycle();

    // Empty list: same-cycle release is not bypassed to the allocator
    alloc_req       = 1'b1;
    release_en      = 1'b1;
    release_preg[0] = 6'd5;
    @(negedge clk);
    chk("nobypass_valid", 32'(alloc_valid[0]), 0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("released_valid", 32'(alloc_valid[0]), 1);
    chk("released_preg", 32'(alloc_preg[0]), 5);
    chk("released_count", 32'(free_count), 1);

    // Reset mid-operation wins over alloc and release
    rst             = 1'b1;
    alloc_req       = 1'b1;
    release_en      = 1'b1;
    release_preg[0] = 6'd9;
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    chk("midrst_count", 32'(free_count), 32);
    chk("midrst_preg", 32'(alloc_preg[0]), 32);
    chk("midrst_empty", 32'(empty), 0);
    next_cycle();

    // 3 allocs, flush with no commits restores the full list
    alloc_run(3, 32);
    flush     = 1'b1;
    alloc_req = 1'b1;
    @(negedge clk);
    chk("flush_valid", 32'(alloc_valid[0]), 0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("flush0_preg", 32'(alloc_preg[0]), 32);
    chk("flush0_count", 32'(free_count), 32);
    next_cycle();

    // 3 allocs, two commits, flush in the second commit cycle
    do_reset();
    alloc_run(3, 32);
    commit_alloc = 1'b1;
    next_cycle();
    commit_alloc = 1'b1;
    flush        = 1'b1;
    alloc_req    = 1'b1;
    @(negedge clk);
    chk("flush2_valid", 32'(alloc_valid[0]), 0);
    next_cycle();
    clear_inputs();
    release_en      = 1'b1;
    release_preg[0] = 6'd7;
    @(negedge clk);
    chk("flush2_preg", 32'(alloc_preg[0]), 34);
    chk("flush2_count", 32'(free_count), 30);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("late_release_count", 32'(free_count), 31);
    next_cycle();
    // Remaining 34..63 come out first, then the released 7 from the tail slot
    alloc_run(30, 34);
    alloc_run(1, 7);
    @(negedge clk);
    chk("refill_empty", 32'(empty), 1);
    next_cycle();

    // Release of preg 0 is ignored
    release_en      = 1'b1;
    release_preg[0] = 6'd0;
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("zero_rel_count", 32'(free_count), 0);
    chk("zero_rel_ovf", 32'(overflow_err), 0);
    next_cycle();

    // Release into a full list is dropped and sets the sticky error
    do_reset();
    release_en      = 1'b1;
    release_preg[0] = 6'd9;
    @(negedge clk);
    chk("full_ovf_before", 32'(overflow_err), 0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("full_ovf", 32'(overflow_err), 1);
    chk("full_count", 32'(free_count), 32);
    chk("full_preg", 32'(alloc_preg[0]), 32);
    next_cycle();
    @(negedge clk);
    chk("ovf_sticky", 32'(overflow_err), 1);
    next_cycle();
    do_reset();
    @(negedge clk);
    chk("ovf_cleared", 32'(overflow_err), 0);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/free_list_ctrl.md
Name: free_list_ctrl

Overview:
- Manages the physical-register free list for the explicit-rename OoO core.
- Hands free physical registers to rename (dequeue) and reclaims registers booted out of the retirement register file (enqueue).
- On branch-mispredict flush, restores the list in one cycle using a commit-side head pointer. Rename state then matches the retired mapping.
- Sits between the rename stage (allocation side) and the ROB/retirement file (commit and release side).

Parameters:
PROCESSOR_WIDTH, 1, lanes per cycle for alloc/commit/release
PHYS_REGS, 64, total physical registers
ARCH_REGS, 32, architectural registers
PHYS_WIDTH, $clog2(PHYS_REGS), physical tag width
DEPTH, PHYS_REGS-ARCH_REGS, free-list capacity
PTR_W, $clog2(DEPTH)+1, pointer width including wrap bit

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
alloc_req[PROCESSOR_WIDTH]  in  1  rename lane i requests a free preg
alloc_valid[PROCESSOR_WIDTH]  out  1  lane i has a grant available this cycle
alloc_preg[PROCESSOR_WIDTH]  out  PHYS_WIDTH  preg offered to lane i
commit_alloc[PROCESSOR_WIDTH]  in  1  committing lane i had arch_dst!=0 (it consumed a preg)
release_en[PROCESSOR_WIDTH]  in  1  retired-preg valid, one cycle after commit
release_preg[PROCESSOR_WIDTH]  in  PHYS_WIDTH  preg booted out of retirement file
flush  in  1  mispredict recovery pulse
free_count  out  PTR_W  entries currently free (tail-head)
empty  out  1  free_count==0
overflow_err  out  1  sticky: release attempted while full

Behaviour:
- Storage: DEPTH-entry circular array of PHYS_WIDTH tags. head, tail and retire_head are PTR_W-bit pointers; the index is the low bits and the MSB is the wrap bit.
- Reset: entry[i]=ARCH_REGS+i; head=0; retire_head=0; tail=DEPTH (wrap bit set, index 0). free_count=DEPTH; empty=0; overflow_err=0.
- Offer (combinational):
  - alloc_preg[i]=entry[head+i].
  - alloc_valid[i]=!flush && free_count>i && (i==0 || fire[i-1]).
  - fire[i]=alloc_req[i]&&alloc_valid[i]. Grants are strictly in order: a lane is never granted if a lower lane is not.
- Allocation: head advances by the number of fire lanes at the next edge. No bypass of same-cycle releases: an empty list stays unavailable that cycle.
- Release: a lane is accepted when release_en[i] && release_preg[i]!=0 (preg 0 is never freed). Accepted lanes write entry[tail+k], where k is that lane's rank among accepted lanes in lane order. tail advances by the accepted count.
- Commit: retire_head advances by popcount(commit_alloc). retire_head never passes head, which is guaranteed by the ROB.
- Flush:
  - head <= retire_head_next, where retire_head_next includes same-cycle commits.
  - Same-cycle alloc is suppressed (alloc_valid=0).
  - Same-cycle and later releases proceed normally; tail is not touched. The release lagging one cycle behind a commit must still land after flush.
- Full: a release that would make free_count>DEPTH is dropped and sets overflow_err. The error is also flagged by assertion.
- Invariants:
  - retire_head <= head <= tail (modular).
  - tail-retire_head <= DEPTH.
  - free_count updates registered, valid the cycle after the event.
- Reset mid-operation wins over all other inputs; state returns to reset values.

Decomposition:
- rv32i_types package holds PHYS_REGS, ARCH_REGS, PHYS_WIDTH, PROCESSOR_WIDTH, FREE_DEPTH and the typedef phys_tag_t.
- One sub-module, fl_lane_select: prefix-popcount over the lane enables, giving per-lane rank and total count. It is reused for the alloc, commit and release sides.

Test Plan:
- Reset -> alloc_preg[0]=32, alloc_valid[0]=1, free_count=32, empty=0.
- 32 back-to-back allocs -> tags 32..63 in order; then empty=1, alloc_valid=0, free_count=0.
- Empty list, release_preg=5 with alloc_req same cycle -> no grant that cycle; next cycle alloc_preg=5, valid=1.
- 3 allocs (32,33,34), no commits, flush -> next cycle alloc_preg=32, free_count=32.
- 3 allocs, commit_alloc on 2 with flush in the second commit cycle -> alloc_preg=34. A following release of preg 7 lands at the tail; free_count goes 30 -> 31.
- release_preg=0 with release_en=1 -> ignored, free_count unchanged. Release when free_count=32 -> dropped, overflow_err=1.
